display_scan_controller: RTL and testbench

- Sequencer for the decimal seven-segment path: accepts an 8-bit binary value over a valid/ready handshake and converts it to three BCD digits with an iterative shift-add-3 loop, 8 cycles per value.
- Holds the digits in a display buffer and time-multiplexes them onto a single digit/place output pair.
- Applies leading-zero blanking.
- Feeds seven_segment_decode_decimal and the digit-select pins at the top level.

---
 rtl/display_scan_controller.sv | 153 +++++++++++++++
 tb/tb_display_scan_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Binary-to-BCD converter (shift-add-3) feeding a free-running three-place digit scanner
// with leading-zero blanking. Optional macro GHOST_GUARD_EN blanks the start of every dwell.
module display_scan_controller #(
  parameter int DWELL_CYCLES = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_value,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [3:0] digit,
  output logic [1:0] digit_place,
  output logic [2:0] digit_enable,
  output logic       blank
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [11:0]   adjusted;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   buffer_q, buffer_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    place_q, place_d;
  logic [3:0]    digit_q, digit_d;
  logic [2:0]    enable_q, enable_d;
  logic          blank_q, blank_d;

  logic [1:0]    next_place;
  logic [3:0]    next_nibble;
  logic          next_blank;
  logic          wrap;

  // Converter: each CONVERT cycle corrects nibbles >= 5 before the combined left shift.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    buffer_d  = buffer_q;
    adjusted  = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_value;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        {scratch_d, shift_d} = {adjusted, shift_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        buffer_d = scratch_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrap        = (cnt_q == CNT_LAST);
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    next_place  = (place_q == 2'd2) ? 2'd0 : place_q + 2'd1;
    next_nibble = 4'd0;
    next_blank  = 1'b0;
    case (next_place)
      2'd2: begin
        next_nibble = buffer_q[11:8];
        next_blank  = (buffer_q[11:8] == 4'd0);
      end
      2'd1: begin
        next_nibble = buffer_q[7:4];
        next_blank  = (buffer_q[11:4] == 8'd0);
      end
      default: begin
        next_nibble = buffer_q[3:0];
        next_blank  = 1'b0;
      end
    endcase
    place_d  = place_q;
    digit_d  = digit_q;
    enable_d = enable_q;
    blank_d  = blank_q;
    // Buffer snapshot is taken only here, so a mid-dwell commit appears at the next place.
    if (wrap) begin
      place_d  = next_place;
      blank_d  = next_blank;
      digit_d  = next_blank ? 4'd0 : next_nibble;
      enable_d = next_blank ? 3'b000 : (3'b001 << next_place);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      buffer_q  <= '0;
      cnt_q     <= '0;
      place_q   <= 2'd0;
      digit_q   <= 4'd0;
      enable_q  <= 3'b001;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      buffer_q  <= buffer_d;
      cnt_q     <= cnt_d;
      place_q   <= place_d;
      digit_q   <= digit_d;
      enable_q  <= enable_d;
      blank_q   <= blank_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign digit       = digit_q;
  assign digit_place = place_q;

`ifdef GHOST_GUARD_EN
  logic guard;
  assign guard        = (cnt_q < CW'(GUARD_CYCLES));
  assign digit_enable = guard ? 3'b000 : enable_q;
  assign blank        = guard ? 1'b1 : blank_q;
`else
  assign digit_enable = enable_q;
  assign blank        = blank_q;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: directed plan steps then random traffic,
// checked every cycle against a value-level model (decimal digits from integer division).
module tb_display_scan_controller;

`ifdef GHOST_GUARD_EN
  localparam int DWELL    = 8;
  localparam int GUARD    = 2;
  localparam bit GUARD_ON = 1'b1;
`else
  localparam int DWELL    = 4;
  localparam int GUARD    = 1;
  localparam bit GUARD_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_value;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic [3:0] digit;
  logic [1:0] digit_place;
  logic [2:0] digit_enable;
  logic       blank;

  int n_compared = 0;
  int n_failed   = 0;

  int edge_n, free_at, commit_at, pending_val, disp_val;
  logic [3:0] m_digit;
  logic [1:0] m_place;
  logic [2:0] m_en;
  logic       m_blank;

  display_scan_controller #(.DWELL_CYCLES(DWELL), .GUARD_CYCLES(GUARD)) dut (
    .clock(clock), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .digit(digit), .digit_place(digit_place),
    .digit_enable(digit_enable), .blank(blank)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input string what, input logic [11:0] obs, input logic [11:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h (edge %0d)", tag, what, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; free_at = 0; commit_at = -1; pending_val = 0; disp_val = 0;
    m_digit = 4'd0; m_place = 2'd0; m_en = 3'b001; m_blank = 1'b0;
  endtask

  // Place p of the committed value, with leading zeros suppressed.
  task automatic load_place(input int p);
    int h, t, o, d;
    bit bl;
    h = disp_val / 100; t = (disp_val / 10) % 10; o = disp_val % 10;
    d  = (p == 2) ? h : (p == 1) ? t : o;
    bl = (p == 2) ? (h == 0) : (p == 1) ? (h == 0 && t == 0) : 1'b0;
    m_place = 2'(p);
    m_blank = bl;
    m_digit = bl ? 4'd0 : 4'(d);
    m_en    = bl ? 3'b000 : 3'(1 << p);
  endtask

  task automatic checkOutput(input string tag);
    bit g, exp_busy;
    g = GUARD_ON && ((edge_n % DWELL) < GUARD);
    exp_busy = (edge_n < free_at);
    cmp(tag, "in_ready", {11'd0, in_ready}, {11'd0, !exp_busy});
    cmp(tag, "busy", {11'd0, busy}, {11'd0, exp_busy});
    cmp(tag, "digit", {8'd0, digit}, {8'd0, m_digit});
    cmp(tag, "digit_place", {10'd0, digit_place}, {10'd0, m_place});
    cmp(tag, "digit_enable", {9'd0, digit_enable}, {9'd0, g ? 3'b000 : m_en});
    cmp(tag, "blank", {11'd0, blank}, {11'd0, g ? 1'b1 : m_blank});
  endtask

  task automatic tick(input string tag);
    bit ready_before;
    ready_before = (edge_n >= free_at);
    @(posedge clock);
    edge_n++;
    if (edge_n % DWELL == 0) load_place((edge_n / DWELL) % 3);
    if (edge_n == commit_at) disp_val = pending_val;
    if (ready_before && in_valid) begin
      pending_val = int'(in_value);
      commit_at   = edge_n + 9;
      free_at     = edge_n + 9;
    end
    #1 checkOutput(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [7:0] val, input int n);
    in_valid = v;
    in_value = val;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_value = 8'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    cmp("reset", "digit_place", {10'd0, digit_place}, 12'd0);
    cmp("reset", "digit", {8'd0, digit}, 12'd0);
    cmp("reset", "in_ready", {11'd0, in_ready}, 12'd1);
    checkOutput("reset");
    @(negedge clock) reset_n = 1'b1;

    applyStimulus("idle_scan", 1'b0, 8'd0, 12);
    applyStimulus("v173", 1'b1, 8'd173, 1);
    applyStimulus("v173", 1'b0, 8'd0, 9 + 3 * DWELL);
    cmp("v173", "model_value", 12'(disp_val), 12'd173);
    applyStimulus("v5", 1'b1, 8'd5, 1);
    applyStimulus("v5", 1'b0, 8'd0, 9 + 3 * DWELL);
    applyStimulus("v40", 1'b1, 8'd40, 1);
    applyStimulus("v40", 1'b0, 8'd0, 9 + 3 * DWELL);
    applyStimulus("v255", 1'b1, 8'd255, 1);
    applyStimulus("v255_hold0", 1'b1, 8'd0, 9);
    applyStimulus("v255_show", 1'b0, 8'd0, 2);
    applyStimulus("v255_show", 1'b0, 8'd0, 3 * DWELL);

    applyStimulus("v99", 1'b1, 8'd99, 1);
    applyStimulus("v99", 1'b0, 8'd0, 4);
    #2 reset_n = 1'b0;
    #1 model_reset();
    checkOutput("async_reset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    applyStimulus("post_reset", 1'b0, 8'd0, 3 * DWELL + 2);

    for (int k = 0; k < 40; k++) begin
      applyStimulus("random", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(1, 14)));
    end
    applyStimulus("drain", 1'b0, 8'd0, 12 + 3 * DWELL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
